vga_timing_gen: RTL

Parametrised VGA timing generator and pixel output stage. It is the successor to the fixed 640x480 VgaDriver.
- Timing, sync polarity, colour depth and system-to-pixel clock ratio are parameters.
- Generates curr_x/curr_y requests for the pixel source one pixel period ahead of the pins, then drives registered, blank-masked RGB plus hs/vs/de.
- Sits between the game renderer (colour source) and the board VGA connector.

---
 rtl/vga_timing_gen_pkg.sv | 37 +++
 rtl/vga_wrap_counter.sv | 30 +++
 rtl/vga_timing_gen.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared definitions for the VGA timing generator.
//   - Default 640x480@60 timing, colour depth and position widths.
//   - seg_e / seg_of(): classify a counter value into the four parts of a
//     line (or frame): active, front porch, sync, back porch.
package vga_timing_gen_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_COLOR_W  = 4;
    localparam int DEF_PIX_DIV  = 4;
    localparam int DEF_X_W      = 10;
    localparam int DEF_Y_W      = 10;

    typedef enum logic [1:0] {
        SEG_ACTIVE,
        SEG_FP,
        SEG_SYNC,
        SEG_BP
    } seg_e;

    // Segments are laid out in the order active, front porch, sync, back porch,
    // so sync can never overlap the active area for any legal timing.
    function automatic seg_e seg_of(input int pos, input int active,
                                    input int fp, input int sync);
        if (pos < active)                  return SEG_ACTIVE;
        else if (pos < active + fp)        return SEG_FP;
        else if (pos < active + fp + sync) return SEG_SYNC;
        else                               return SEG_BP;
    endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Enabled modulo-MAX counter.
//   clk  : clock
//   rst  : synchronous active-high reset, clears cnt
//   en   : advance by one
//   cnt  : current count, 0..MAX-1
//   wrap : combinational, high when en is set and cnt is at MAX-1
module vga_wrap_counter #(
    parameter int MAX = 800,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator and pixel output stage.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   color       : {R,G,B} for the pixel at curr_x/curr_y
//   curr_x/y    : position requested from the pixel source (one pixel ahead)
//   req         : curr_x/curr_y lie in the active area
//   r, g, b     : registered colour, zero when blanked
//   hs, vs      : registered sync outputs, polarity from HS_POL/VS_POL
//   de, rdyn    : output pixel is active video / its inverse
//   pix_ce      : one-clk pixel strobe
//   frame_start : one-clk pulse after pixel (0,0) is registered to the pins
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = DEF_COLOR_W,
    parameter int PIX_DIV  = DEF_PIX_DIV,
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3*COLOR_W-1:0] color,
    output logic [X_W-1:0]       curr_x,
    output logic [Y_W-1:0]       curr_y,
    output logic                 req,
    output logic [COLOR_W-1:0]   r,
    output logic [COLOR_W-1:0]   g,
    output logic [COLOR_W-1:0]   b,
    output logic                 hs,
    output logic                 vs,
    output logic                 de,
    output logic                 rdyn,
    output logic                 pix_ce,
    output logic                 frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    if (X_W < $clog2(H_TOTAL)) begin : g_bad_x_w
        $error("X_W too narrow for H_TOTAL");
    end
    if (Y_W < $clog2(V_TOTAL)) begin : g_bad_y_w
        $error("Y_W too narrow for V_TOTAL");
    end

    logic [DIV_W-1:0] div_cnt;
    logic [X_W-1:0]   cnt_h_p0;
    logic [Y_W-1:0]   cnt_v_p0;
    logic             h_wrap;
    logic             v_wrap;
    logic             at_origin_p0;
    seg_e             hseg_p0;
    seg_e             vseg_p0;

    // ---- Stage p0: pixel divider, position counters, request ----
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Gated by rst so the strobe is low during reset even when PIX_DIV = 1.
    assign pix_ce = !rst && (div_cnt == DIV_LAST);

    vga_wrap_counter #(.MAX(H_TOTAL), .W(X_W)) u_cnt_h (
        .clk  (clk),
        .rst  (rst),
        .en   (pix_ce),
        .cnt  (cnt_h_p0),
        .wrap (h_wrap)
    );

    vga_wrap_counter #(.MAX(V_TOTAL), .W(Y_W)) u_cnt_v (
        .clk  (clk),
        .rst  (rst),
        .en   (h_wrap),
        .cnt  (cnt_v_p0),
        .wrap (v_wrap)
    );

    // Tracks "counters are at (0,0)": true out of reset and after the last
    // pixel of a frame, so frame_start needs no wide compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            at_origin_p0 <= 1'b1;
        end else if (pix_ce) begin
            at_origin_p0 <= v_wrap;
        end
    end

    assign hseg_p0 = seg_of(int'(cnt_h_p0), H_ACTIVE, H_FP, H_SYNC);
    assign vseg_p0 = seg_of(int'(cnt_v_p0), V_ACTIVE, V_FP, V_SYNC);

    assign curr_x = cnt_h_p0;
    assign curr_y = cnt_v_p0;
    assign req    = (hseg_p0 == SEG_ACTIVE) && (vseg_p0 == SEG_ACTIVE);

    // ---- Stage p1: registered pins, one pixel period behind the request ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r           <= '0;
            g           <= '0;
            b           <= '0;
            de          <= 1'b0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce && at_origin_p0;
            if (pix_ce) begin
                de <= req;
                r  <= req ? color[3*COLOR_W-1 -: COLOR_W] : '0;
                g  <= req ? color[2*COLOR_W-1 -: COLOR_W] : '0;
                b  <= req ? color[COLOR_W-1   -: COLOR_W] : '0;
                hs <= (hseg_p0 == SEG_SYNC) ? HS_POL : ~HS_POL;
                vs <= (vseg_p0 == SEG_SYNC) ? VS_POL : ~VS_POL;
            end
        end
    end

    assign rdyn = ~de;

endmodule
